// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, count-derived
// status flags and one-cycle overrun/underrun error pulses.
//
// Handshake: there is no valid/ready pair. A write is taken on a rising edge
// when wr_enb=1 and the FIFO is not full, or is full with rd_enb=1 in the same
// cycle. A read is taken when rd_enb=1 and the FIFO is not empty; the word
// appears on rd_data just after that edge. The producer must watch fifo_full
// and the consumer fifo_empty. A request that cannot be taken is dropped and
// flagged by a one-cycle fifo_overrun or fifo_underrun pulse.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_enb,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic                  fifo_overrun,
  output logic                  fifo_underrun
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;

  logic full, empty;
  logic wr_accept, rd_accept;

  // Status flags come only from the registered count.
  always_comb begin
    full  = (count_q == CNT_FULL);
    empty = (count_q == '0);
  end

  // Accept decisions, next-state pointers, count, read data and error pulses.
  always_comb begin
    // A full FIFO can still take a write if a read frees a slot on the same edge.
    wr_accept  = wr_enb && (!full || rd_enb);
    // An empty FIFO never forwards a same-cycle write to rd_data.
    rd_accept  = rd_enb && !empty;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    overrun_d  = wr_enb && full && !rd_enb;
    underrun_d = rd_enb && empty;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage array; contents are don't-care after reset so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Output mapping.
  always_comb begin
    rd_data           = rd_data_q;
    fifo_full         = full;
    fifo_empty        = empty;
    fifo_almost_full  = (count_q >= (CNT_FULL - CNT_ONE));
    fifo_almost_empty = (count_q <= CNT_ONE);
    fifo_overrun      = overrun_q;
    fifo_underrun     = underrun_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo with a queue scoreboard.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] wr_data = '0;
  logic          wr_enb = 1'b0;
  logic          rd_enb = 1'b0;
  logic [DW-1:0] rd_data;
  logic fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic fifo_overrun, fifo_underrun;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_data           (wr_data),
    .wr_enb            (wr_enb),
    .rd_enb            (rd_enb),
    .rd_data           (rd_data),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_overrun      (fifo_overrun),
    .fifo_underrun     (fifo_underrun)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd = '0;
  logic          exp_ovr = 1'b0;
  logic          exp_udr = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the scoreboard model.
  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check_eq("rd_data",      32'(rd_data),           32'(exp_rd));
    check_eq("empty",        32'(fifo_empty),        32'(sz == 0));
    check_eq("full",         32'(fifo_full),         32'(sz == DEPTH));
    check_eq("almost_full",  32'(fifo_almost_full),  32'(sz >= DEPTH - 1));
    check_eq("almost_empty", 32'(fifo_almost_empty), 32'(sz <= 1));
    check_eq("overrun",      32'(fifo_overrun),      32'(exp_ovr));
    check_eq("underrun",     32'(fifo_underrun),     32'(exp_udr));
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge: drives one cycle of stimulus, predicts the
  // result, then checks #1 after the next rising edge.
  task automatic drive_cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
    logic was_full, was_empty;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    wr_enb  = wr;
    rd_enb  = rd;
    wr_data = d;
    exp_ovr = wr && was_full && !rd;
    exp_udr = rd && was_empty;
    if (rd && !was_empty) exp_rd = exp_q.pop_front();
    if (wr && (!was_full || rd)) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_enb = 1'b0;
    rd_enb = 1'b0;
    check_all();
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two cycles.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Single word.
    drive_cycle(1'b1, 1'b0, 8'hA5);
    drive_cycle(1'b0, 1'b1, 8'h00);
    check_eq("single_rd", 32'(rd_data), 32'h0000_00A5);

    // Fill 10..17, then overrun with FF.
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 8'(8'h10 + i));
    drive_cycle(1'b1, 1'b0, 8'hFF);
    idle_cycle();

    // Drain 8, then one underrun read.
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 8'h00);
    check_eq("drain_last", 32'(rd_data), 32'h0000_0017);
    drive_cycle(1'b0, 1'b1, 8'h00);
    check_eq("underrun_hold", 32'(rd_data), 32'h0000_0017);
    idle_cycle();

    // Wrap-around: 5 in/out, then 20..27 in/out.
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 8'h00);
    check_eq("wrap_last", 32'(rd_data), 32'h0000_0027);

    // Simultaneous on full, then on empty.
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 8'(8'h30 + i));
    drive_cycle(1'b1, 1'b1, 8'h99);
    check_eq("simul_full_rd", 32'(rd_data), 32'h0000_0030);
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 8'h00);
    check_eq("simul_99_out", 32'(rd_data), 32'h0000_0099);
    drive_cycle(1'b1, 1'b1, 8'h5C);
    drive_cycle(1'b0, 1'b1, 8'h00);
    check_eq("simul_empty_rd", 32'(rd_data), 32'h0000_005C);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)));
    end

    // Reset mid-operation, asserted away from the clock edge.
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 8'(8'h40 + i));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_rd  = '0;
    exp_ovr = 1'b0;
    exp_udr = 1'b0;
    check_all();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    drive_cycle(1'b1, 1'b0, 8'h6E);
    drive_cycle(1'b0, 1'b1, 8'h00);
    check_eq("post_reset_rd", 32'(rd_data), 32'h0000_006E);
    drive_cycle(1'b0, 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
